// File: rtl/xm_mem_access_unit.sv
// X-Makina multi-cycle load/store engine: effective-address formation, req/ack bus
// handshake with byte enables, aligned/extended read return and fault reporting.
module xm_mem_access_unit #(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic                          byteOp_i,
  input  logic                          sext_i,
  input  logic [1:0]                    mode_i,
  input  logic [WORD-1:0]               base_i,
  input  logic [WORD-1:0]               offs_i,
  input  logic [WORD-1:0]               wdata_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          fault_o,
  output logic [1:0]                    faultCode_o,
  output logic [WORD-1:0]               rdata_o,
  output logic [WORD-1:0]               addrWb_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [WORD-$clog2(WORD/8)-1:0] mem_adr_o,
  output logic [WORD/8-1:0]             mem_be_o,
  output logic [WORD-1:0]               mem_wdat_o,
  input  logic [WORD-1:0]               mem_rdat_i,
  input  logic                          mem_ack_i
);
  localparam int LANES = WORD / 8;
  localparam int LB    = $clog2(LANES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] F_MISALIGN = 2'b01;
  localparam logic [1:0] F_MODE     = 2'b10;
  localparam logic [1:0] F_TIMEOUT  = 2'b11;

  function automatic logic [WORD-1:0] extend_byte(input logic [7:0] b, input logic sext);
    logic signed [7:0]      sb;
    logic signed [WORD-1:0] sw;
    sb = signed'(b);
    sw = WORD'(sb);
    return sext ? unsigned'(sw) : {{(WORD-8){1'b0}}, b};
  endfunction

  logic [1:0]      state_q;
  logic [7:0]      cnt_q;
  logic [WORD-1:0] ea_q;
  logic [WORD-1:0] wb_q;
  logic [WORD-1:0] base_q;
  logic [WORD-1:0] wdat_q;
  logic [WORD-1:0] rdata_q;
  logic [1:0]      code_q;
  logic            we_q;
  logic            byte_q;
  logic            sext_q;

  logic [WORD-1:0]  step_c;
  logic [WORD-1:0]  ea_c;
  logic [WORD-1:0]  wb_c;
  logic             misalign_c;
  logic [7:0]       rbyte_c;
  logic [LANES-1:0] lane_be_c;

  // Address generation for the access being accepted in IDLE; wrap-around is intended.
  always_comb begin
    step_c = byteOp_i ? WORD'(1) : WORD'(LANES);
    ea_c   = base_i;
    wb_c   = base_i;
    case (mode_i)
      2'b00: begin
        ea_c = base_i + offs_i;
        wb_c = base_i;
      end
      2'b01: begin
        ea_c = base_i;
        wb_c = base_i + step_c;
      end
      2'b10: begin
        ea_c = base_i - step_c;
        wb_c = base_i - step_c;
      end
      default: begin
        ea_c = base_i;
        wb_c = base_i;
      end
    endcase
    misalign_c = !byteOp_i && (ea_c[LB-1:0] != '0);
  end

  always_comb begin
    rbyte_c   = '0;
    lane_be_c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ea_q[LB-1:0] == LB'(i)) begin
        rbyte_c      = mem_rdat_i[8*i +: 8];
        lane_be_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ea_q    <= '0;
      wb_q    <= '0;
      base_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      code_q  <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            ea_q   <= ea_c;
            wb_q   <= wb_c;
            base_q <= base_i;
            wdat_q <= wdata_i;
            we_q   <= we_i;
            byte_q <= byteOp_i;
            sext_q <= sext_i;
            cnt_q  <= '0;
            if (mode_i == 2'b11) begin
              code_q  <= F_MODE;
              state_q <= S_FAULT;
            end else if (misalign_c) begin
              code_q  <= F_MISALIGN;
              state_q <= S_FAULT;
            end else begin
              code_q  <= '0;
              state_q <= S_REQ;
            end
          end
        end
        // Bus phase: an ack always beats the timeout in the same cycle.
        S_REQ: begin
          if (mem_ack_i) begin
            if (!we_q) begin
              rdata_q <= byte_q ? extend_byte(rbyte_c, sext_q) : mem_rdat_i;
            end
            state_q <= S_DONE;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            code_q  <= F_TIMEOUT;
            state_q <= S_FAULT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE) || (state_q == S_FAULT);
  assign fault_o     = (state_q == S_FAULT);
  assign faultCode_o = (state_q == S_FAULT) ? code_q : 2'b00;
  assign rdata_o     = rdata_q;
  assign addrWb_o    = (state_q == S_FAULT) ? base_q : wb_q;

  assign mem_req_o  = (state_q == S_REQ);
  assign mem_we_o   = (state_q == S_REQ) && we_q;
  assign mem_adr_o  = (state_q == S_REQ) ? ea_q[WORD-1:LB] : '0;
  assign mem_be_o   = (state_q != S_REQ) ? '0 : (byte_q ? lane_be_c : '1);
  assign mem_wdat_o = (state_q != S_REQ) ? '0 : (byte_q ? {LANES{wdat_q[7:0]}} : wdat_q);
endmodule

// File: tb/tb_xm_mem_access_unit.sv
// Directed bench for xm_mem_access_unit: bus responder driven inline, completions
// compared against a queue of expected results.
module tb_xm_mem_access_unit;
  logic        clk = 1'b0;
  logic        arst_ni;
  logic        req_i, we_i, byteOp_i, sext_i;
  logic [1:0]  mode_i;
  logic [15:0] base_i, offs_i, wdata_i;
  logic        busy_o, done_o, fault_o;
  logic [1:0]  faultCode_o;
  logic [15:0] rdata_o, addrWb_o;
  logic        mem_req_o, mem_we_o;
  logic [14:0] mem_adr_o;
  logic [1:0]  mem_be_o;
  logic [15:0] mem_wdat_o, mem_rdat_i;
  logic        mem_ack_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fault;
    logic [1:0]  code;
    logic [15:0] rdata;
    logic [15:0] wb;
  } exp_t;
  exp_t sb[$];

  xm_mem_access_unit #(.WORD(16), .TIMEOUT(15)) dut (
    .clk_i(clk), .arst_ni(arst_ni), .req_i(req_i), .we_i(we_i), .byteOp_i(byteOp_i),
    .sext_i(sext_i), .mode_i(mode_i), .base_i(base_i), .offs_i(offs_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .faultCode_o(faultCode_o),
    .rdata_o(rdata_o), .addrWb_o(addrWb_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o), .mem_be_o(mem_be_o), .mem_wdat_o(mem_wdat_o),
    .mem_rdat_i(mem_rdat_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic f, input logic [1:0] c, input logic [15:0] r, input logic [15:0] w);
    exp_t e;
    e.fault = f; e.code = c; e.rdata = r; e.wb = w;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_fault"}, 32'(fault_o), 32'(e.fault));
      chk({tag, "_code"}, 32'(faultCode_o), 32'(e.code));
      chk({tag, "_rdata"}, 32'(rdata_o), 32'(e.rdata));
      chk({tag, "_addrwb"}, 32'(addrWb_o), 32'(e.wb));
    end
  endtask

  task automatic start(input logic we, input logic bop, input logic sx, input logic [1:0] md,
                       input logic [15:0] b, input logic [15:0] o, input logic [15:0] w);
    req_i = 1'b1; we_i = we; byteOp_i = bop; sext_i = sx; mode_i = md;
    base_i = b; offs_i = o; wdata_i = w;
    tick();
    req_i = 1'b0;
  endtask

  task automatic ack_once(input logic [15:0] d);
    mem_ack_i = 1'b1; mem_rdat_i = d;
    tick();
    mem_ack_i = 1'b0; mem_rdat_i = 16'h0000;
  endtask

  initial begin
    arst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; byteOp_i = 1'b0; sext_i = 1'b0;
    mode_i = 2'b00; base_i = '0; offs_i = '0; wdata_i = '0; mem_rdat_i = '0; mem_ack_i = 1'b0;
    #3;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_memreq", 32'(mem_req_o), 0);
    chk("rst_rdata", 32'(rdata_o), 0);
    chk("rst_addrwb", 32'(addrWb_o), 0);
    chk("rst_code", 32'(faultCode_o), 0);
    #4 arst_ni = 1'b1;
    tick();

    // Word load, indexed, ack after two wait cycles
    push(1'b0, 2'b00, 16'hBEEF, 16'h1000);
    start(1'b0, 1'b0, 1'b0, 2'b00, 16'h1000, 16'h0004, 16'h0000);
    chk("wl_req", 32'(mem_req_o), 1);
    chk("wl_adr", 32'(mem_adr_o), 32'h0802);
    chk("wl_be", 32'(mem_be_o), 32'h3);
    chk("wl_we", 32'(mem_we_o), 0);
    chk("wl_busy", 32'(busy_o), 1);
    tick();
    chk("wl_adr_hold", 32'(mem_adr_o), 32'h0802);
    chk("wl_nodone", 32'(done_o), 0);
    tick();
    ack_once(16'hBEEF);
    chk("wl_req_drop", 32'(mem_req_o), 0);
    pop_check("wl");
    tick();
    chk("wl_idle_done", 32'(done_o), 0);

    // Byte load, sign-extended then zero-extended, back-to-back
    push(1'b0, 2'b00, 16'hFF80, 16'h2002);
    start(1'b0, 1'b1, 1'b1, 2'b01, 16'h2001, 16'h0000, 16'h0000);
    chk("bls_be", 32'(mem_be_o), 32'h2);
    ack_once(16'h80AA);
    pop_check("bls");
    tick();
    push(1'b0, 2'b00, 16'h0080, 16'h2002);
    start(1'b0, 1'b1, 1'b0, 2'b01, 16'h2001, 16'h0000, 16'h0000);
    ack_once(16'h80AA);
    pop_check("blz");
    tick();

    // Byte store, post-inc, wrap-around
    push(1'b0, 2'b00, 16'h0080, 16'h0000);
    start(1'b1, 1'b1, 1'b0, 2'b01, 16'hFFFF, 16'h0000, 16'hAB34);
    chk("bs_we", 32'(mem_we_o), 1);
    chk("bs_be", 32'(mem_be_o), 32'h2);
    chk("bs_wdat", 32'(mem_wdat_o), 32'h3434);
    chk("bs_adr", 32'(mem_adr_o), 32'h7FFF);
    ack_once(16'hFFFF);
    pop_check("bs");
    tick();

    // Misaligned word load faults in IDLE
    push(1'b1, 2'b01, 16'h0080, 16'h0003);
    start(1'b0, 1'b0, 1'b0, 2'b00, 16'h0003, 16'h0000, 16'h0000);
    chk("mis_req", 32'(mem_req_o), 0);
    pop_check("mis");
    tick();
    chk("mis_req2", 32'(mem_req_o), 0);

    // Illegal mode beats misalignment
    push(1'b1, 2'b10, 16'h0080, 16'h0005);
    start(1'b1, 1'b0, 1'b0, 2'b11, 16'h0005, 16'h0000, 16'h0000);
    chk("ill_we", 32'(mem_we_o), 0);
    pop_check("ill");
    tick();

    // Timeout: 15 request cycles with no ack
    push(1'b1, 2'b11, 16'h0080, 16'h0040);
    start(1'b0, 1'b0, 1'b0, 2'b01, 16'h0040, 16'h0000, 16'h0000);
    for (int i = 0; i < 15; i++) begin
      chk("to_req", 32'(mem_req_o), 1);
      tick();
    end
    chk("to_req_drop", 32'(mem_req_o), 0);
    pop_check("to");
    tick();

    // Ack in the 15th wait cycle still completes normally
    push(1'b0, 2'b00, 16'h5A5A, 16'h0080);
    start(1'b0, 1'b0, 1'b0, 2'b00, 16'h0080, 16'h0000, 16'h0000);
    for (int i = 0; i < 14; i++) tick();
    chk("late_req", 32'(mem_req_o), 1);
    ack_once(16'h5A5A);
    pop_check("late");
    tick();

    // Pre-dec word store
    push(1'b0, 2'b00, 16'h5A5A, 16'h00FE);
    start(1'b1, 1'b0, 1'b0, 2'b10, 16'h0100, 16'h0000, 16'hC3D2);
    chk("pd_adr", 32'(mem_adr_o), 32'h007F);
    chk("pd_be", 32'(mem_be_o), 32'h3);
    chk("pd_wdat", 32'(mem_wdat_o), 32'hC3D2);
    chk("pd_we", 32'(mem_we_o), 1);
    ack_once(16'h0000);
    pop_check("pd");
    tick();

    // Asynchronous reset in the middle of a request
    start(1'b0, 1'b0, 1'b0, 2'b00, 16'h0200, 16'h0000, 16'h0000);
    chk("ar_req", 32'(mem_req_o), 1);
    #2 arst_ni = 1'b0;
    #1;
    chk("ar_req_drop", 32'(mem_req_o), 0);
    chk("ar_busy", 32'(busy_o), 0);
    chk("ar_done", 32'(done_o), 0);
    #2 arst_ni = 1'b1;
    tick();
    chk("ar_done2", 32'(done_o), 0);
    push(1'b0, 2'b00, 16'h1111, 16'h0300);
    start(1'b0, 1'b0, 1'b0, 2'b00, 16'h0300, 16'h0000, 16'h0000);
    ack_once(16'h1111);
    pop_check("post_rst");
    tick();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
